// File: rtl/ms_flop_pkg.sv
// Shared mode encodings and next-state rule for the master-slave flop bank.
// Imported by ms_flop_cell and ms_flop_bank.
package ms_flop_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // Next master bit for one cell; the illegal SR case holds the current value.
    function automatic logic next_master(
        input logic [1:0] mode,
        input logic       a,
        input logic       b,
        input logic       qm
    );
        logic nxt;
        nxt = qm;
        unique case (mode)
            MODE_JK: begin
                unique case ({a, b})
                    2'b00:   nxt = qm;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = ~qm;
                endcase
            end
            MODE_SR: begin
                unique case ({a, b})
                    2'b00:   nxt = qm;
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = qm;
                endcase
            end
            MODE_D:  nxt = a;
            default: nxt = qm ^ a;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ms_flop_cell.sv
// One configurable master-slave flop: master/slave bits, 2-bit mode register,
// and illegal-SR detection (per-cycle pulse plus sticky flag).
module ms_flop_cell
    import ms_flop_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       cfg_we,
    input  logic [1:0] cfg_mode,
    input  logic       en,
    input  logic       a,
    input  logic       b,
    input  logic       ill_clr,
    output logic       qm,
    output logic       q,
    output logic [1:0] mode,
    output logic       illegal,
    output logic       ill_pulse
);

    logic       qm_q, qm_d;
    logic       q_q;
    logic [1:0] mode_q, mode_d;
    logic       ill_q, ill_d;
    logic       ill_event;

    always_comb begin
        ill_event = en && (mode_q == MODE_SR) && a && b;
        qm_d      = en ? next_master(mode_q, a, b, qm_q) : qm_q;
        mode_d    = cfg_we ? cfg_mode : mode_q;
        // A new illegal event beats a simultaneous clear.
        if (ill_event) begin
            ill_d = 1'b1;
        end else if (ill_clr) begin
            ill_d = 1'b0;
        end else begin
            ill_d = ill_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            qm_q   <= 1'b0;
            q_q    <= 1'b0;
            mode_q <= MODE_JK;
            ill_q  <= 1'b0;
        end else begin
            qm_q   <= qm_d;
            q_q    <= qm_q;
            mode_q <= mode_d;
            ill_q  <= ill_d;
        end
    end

    assign qm        = qm_q;
    assign q         = q_q;
    assign mode      = mode_q;
    assign illegal   = ill_q;
    assign ill_pulse = ill_event;

endmodule

// File: rtl/ms_flop_bank.sv
// Bank of WIDTH programmable master-slave flops with a shared saturating
// counter of cycles in which any cell saw an illegal SR input.
module ms_flop_bank
    import ms_flop_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CFG_WE,
    input  logic [2*WIDTH-1:0] CFG_MODE,
    input  logic               EN,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               ILL_CLR,
    output logic [WIDTH-1:0]   QM,
    output logic [WIDTH-1:0]   Q,
    output logic [2*WIDTH-1:0] MODE,
    output logic [WIDTH-1:0]   ILLEGAL,
    output logic [CNT_W-1:0]   ERR_CNT
);

    logic [WIDTH-1:0] ill_pulse;
    logic             any_ill;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ms_flop_cell u_cell (
            .CLK       (CLK),
            .RST       (RST),
            .cfg_we    (CFG_WE),
            .cfg_mode  (CFG_MODE[2*i +: 2]),
            .en        (EN),
            .a         (A[i]),
            .b         (B[i]),
            .ill_clr   (ILL_CLR),
            .qm        (QM[i]),
            .q         (Q[i]),
            .mode      (MODE[2*i +: 2]),
            .illegal   (ILLEGAL[i]),
            .ill_pulse (ill_pulse[i])
        );
    end

    // Several cells failing in one cycle still count as a single event.
    always_comb begin
        any_ill   = |ill_pulse;
        err_cnt_d = err_cnt_q;
        if (any_ill && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_ms_flop_bank.sv
// Self-checking bench for ms_flop_bank: directed scenarios plus random traffic
// compared against a behavioural model of the bank.
module tb_ms_flop_bank;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          CLK;
    logic          RST;
    logic          CFG_WE;
    logic [2*W-1:0] CFG_MODE;
    logic          EN;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          ILL_CLR;
    logic [W-1:0]  QM;
    logic [W-1:0]  Q;
    logic [2*W-1:0] MODE;
    logic [W-1:0]  ILLEGAL;
    logic [CW-1:0] ERR_CNT;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [W-1:0]   m_qm, m_q, m_ill;
    logic [2*W-1:0] m_mode;
    int             m_cnt;

    ms_flop_bank #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CFG_WE   (CFG_WE),
        .CFG_MODE (CFG_MODE),
        .EN       (EN),
        .A        (A),
        .B        (B),
        .ILL_CLR  (ILL_CLR),
        .QM       (QM),
        .Q        (Q),
        .MODE     (MODE),
        .ILLEGAL  (ILLEGAL),
        .ERR_CNT  (ERR_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one edge, stepping the model with the inputs present at that edge.
    task automatic tick();
        logic [W-1:0]   nqm, nill;
        logic [2*W-1:0] nmode;
        int             ncnt, md;
        bit             bad_any;
        if (RST) begin
            nqm = '0; nill = '0; nmode = '0; ncnt = 0;
        end else begin
            nqm = m_qm; nill = m_ill; bad_any = 0;
            for (int i = 0; i < W; i++) begin
                md = (int'(m_mode) >> (2 * i)) & 3;
                if (EN) begin
                    if (md == 0) begin
                        if (A[i] && B[i]) nqm[i] = !m_qm[i];
                        else if (A[i])    nqm[i] = 1'b1;
                        else if (B[i])    nqm[i] = 1'b0;
                    end else if (md == 1) begin
                        if (A[i] && B[i]) bad_any = 1;
                        else if (A[i])    nqm[i] = 1'b1;
                        else if (B[i])    nqm[i] = 1'b0;
                    end else if (md == 2) begin
                        nqm[i] = A[i];
                    end else begin
                        if (A[i]) nqm[i] = !m_qm[i];
                    end
                end
                if (EN && md == 1 && A[i] && B[i]) nill[i] = 1'b1;
                else if (ILL_CLR)                  nill[i] = 1'b0;
            end
            nmode = CFG_WE ? CFG_MODE : m_mode;
            ncnt  = m_cnt;
            if (bad_any && m_cnt < (1 << CW) - 1) ncnt = m_cnt + 1;
        end
        @(posedge CLK);
        #1;
        m_q    = RST ? '0 : m_qm;
        m_qm   = nqm;
        m_ill  = nill;
        m_mode = nmode;
        m_cnt  = ncnt;
    endtask

    task automatic idle_inputs();
        RST = 0; CFG_WE = 0; CFG_MODE = '0; EN = 0; A = '0; B = '0; ILL_CLR = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        RST = 1;
        tick();
        RST = 0;
        tests++;
        if ({QM, Q, MODE, ILLEGAL, ERR_CNT} !== '0) begin
            fails++;
            $display("FAIL reset: QM=%h Q=%h MODE=%h ILL=%h CNT=%0d, want all 0",
                     QM, Q, MODE, ILLEGAL, ERR_CNT);
        end
    endtask

    task automatic test_jk();
        EN = 1; A = 4'b1010; B = 4'b0110;
        tick();
        // bit3 set, bit2 clear, bit1 toggles 0->1, bit0 holds
        tests++;
        if (QM !== 4'b1010) begin
            fails++; $display("FAIL jk_first: QM=%b want 1010", QM);
        end
        tick();
        // bit1 toggles back to 0, others stay
        tests++;
        if (QM !== 4'b1000) begin
            fails++; $display("FAIL jk_second: QM=%b want 1000", QM);
        end
        tests++;
        if (Q !== 4'b1010) begin
            fails++; $display("FAIL jk_slave: Q=%b want 1010", Q);
        end
        EN = 0;
    endtask

    task automatic test_mode_write();
        CFG_MODE = 8'b11_11_11_11; CFG_WE = 1; EN = 1; A = 4'hF; B = 4'h0;
        tick();
        CFG_WE = 0;
        tests++;
        if (QM !== 4'hF || MODE !== 8'hFF) begin
            fails++; $display("FAIL mode_same_cycle: QM=%h MODE=%h want F FF", QM, MODE);
        end
        tick();
        tests++;
        if (QM !== 4'h0) begin
            fails++; $display("FAIL mode_t_toggle: QM=%h want 0", QM);
        end
        EN = 0;
    endtask

    task automatic test_d_hold();
        CFG_MODE = 8'b10_10_10_10; CFG_WE = 1; EN = 0;
        tick();
        CFG_WE = 0; EN = 1; A = 4'h5;
        tick();
        tests++;
        if (QM !== 4'h5) begin
            fails++; $display("FAIL d_load: QM=%h want 5", QM);
        end
        tick();
        tests++;
        if (Q !== 4'h5) begin
            fails++; $display("FAIL d_slave: Q=%h want 5", Q);
        end
        EN = 0; A = 4'hA;
        tick();
        tests++;
        if (QM !== 4'h5) begin
            fails++; $display("FAIL en_hold: QM=%h want 5", QM);
        end
    endtask

    task automatic test_illegal_sat();
        CFG_MODE = 8'b01_01_01_01; CFG_WE = 1;
        tick();
        CFG_WE = 0; EN = 1; A = 4'h3; B = 4'hC;
        tick();
        tests++;
        if (QM !== 4'h3 || ERR_CNT !== 2'd0) begin
            fails++; $display("FAIL sr_setup: QM=%h CNT=%0d want 3 0", QM, ERR_CNT);
        end
        A = 4'h1; B = 4'h1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            tests++;
            if (QM !== 4'h3 || ILLEGAL !== 4'h1 || ERR_CNT !== CW'(k > 3 ? 3 : k)) begin
                fails++;
                $display("FAIL sr_illegal_%0d: QM=%h ILL=%h CNT=%0d want 3 1 %0d",
                         k, QM, ILLEGAL, ERR_CNT, (k > 3 ? 3 : k));
            end
        end
        ILL_CLR = 1;
        tick();
        tests++;
        if (ILLEGAL !== 4'h1) begin
            fails++; $display("FAIL clr_vs_set: ILL=%h want 1", ILLEGAL);
        end
        A = 4'h0; B = 4'h0;
        tick();
        ILL_CLR = 0;
        tests++;
        if (ILLEGAL !== 4'h0 || ERR_CNT !== 2'd3) begin
            fails++; $display("FAIL clr: ILL=%h CNT=%0d want 0 3", ILLEGAL, ERR_CNT);
        end
        EN = 0;
    endtask

    task automatic test_reset_mid();
        CFG_MODE = 8'b10_10_10_10; CFG_WE = 1; EN = 0;
        tick();
        CFG_WE = 0; EN = 1; A = 4'h5;
        tick();
        A = 4'hA;
        tick();
        tests++;
        if (QM !== 4'hA || Q !== 4'h5) begin
            fails++; $display("FAIL mid_setup: QM=%h Q=%h want A 5", QM, Q);
        end
        RST = 1; CFG_WE = 1; CFG_MODE = 8'hFF; ILL_CLR = 1;
        tick();
        RST = 0; CFG_WE = 0; ILL_CLR = 0; EN = 0;
        tests++;
        if ({QM, Q, MODE, ILLEGAL, ERR_CNT} !== '0) begin
            fails++;
            $display("FAIL reset_mid: QM=%h Q=%h MODE=%h ILL=%h CNT=%0d, want all 0",
                     QM, Q, MODE, ILLEGAL, ERR_CNT);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            RST      = ($urandom_range(0, 49) == 0);
            CFG_WE   = ($urandom_range(0, 7) == 0);
            CFG_MODE = 8'($urandom);
            EN       = ($urandom_range(0, 3) != 0);
            A        = 4'($urandom);
            B        = 4'($urandom);
            ILL_CLR  = ($urandom_range(0, 9) == 0);
            tick();
            tests++;
            if (QM !== m_qm || Q !== m_q || MODE !== m_mode || ILLEGAL !== m_ill ||
                ERR_CNT !== CW'(m_cnt)) begin
                fails++;
                $display("FAIL random_%0d: QM=%h Q=%h MODE=%h ILL=%h CNT=%0d want %h %h %h %h %0d",
                         n, QM, Q, MODE, ILLEGAL, ERR_CNT, m_qm, m_q, m_mode, m_ill, m_cnt);
            end
        end
    endtask

    initial begin
        m_qm = '0; m_q = '0; m_ill = '0; m_mode = '0; m_cnt = 0;
        test_reset();
        test_jk();
        test_mode_write();
        test_d_hold();
        test_illegal_sat();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
